// File: rtl/calc_alu_if.sv
// Operand/result bundle between the operand stage, the ALU and the display stage.
// Launch: a rising edge on start captures the operands; done pulses once when results are ready.
interface calc_alu_if #(
  parameter int WIDTH = 4
) ();
  logic                 start;
  logic [WIDTH-1:0]     first_nr;
  logic [WIDTH-1:0]     second_nr;
  logic [3:0]           operation;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, first_nr, second_nr, operation,
    input  result, remainder, busy, done, err
  );

  modport slave (
    input  start, first_nr, second_nr, operation,
    output result, remainder, busy, done, err
  );
endinterface

// File: rtl/calc_alu_seq.sv
// Sequential signed ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied in a final step.
module calc_alu_seq #(
  parameter int         WIDTH  = 4,
  parameter logic [3:0] OP_ADD = 4'hA,
  parameter logic [3:0] OP_SUB = 4'hB,
  parameter logic [3:0] OP_MUL = 4'hC,
  parameter logic [3:0] OP_DIV = 4'hD
) (
  input  logic         clk,
  input  logic         rst,
  calc_alu_if.slave    alu_bus,
  output logic [2:0]   state_o
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_SIGN, S_DONE} state_t;

  state_t           state_q;
  logic             start_prev_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [RW-1:0]    mcand_q, acc_q;
  logic [WIDTH:0]   mplier_q, divisor_q, rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    result_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q, done_q, err_q;

  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] x;
    x = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -x : x;
  endfunction

  logic             launch;
  logic [WIDTH:0]   mag_a, mag_b, rem_sh;
  logic             rem_ge;
  logic             sign_q;
  logic [RW-1:0]    quo_ext;

  // Edge detect runs in every state, so a level held through busy never relaunches.
  assign launch  = (state_q == S_IDLE) && alu_bus.start && !start_prev_q;
  assign mag_a   = magnitude(alu_bus.first_nr);
  assign mag_b   = magnitude(alu_bus.second_nr);
  assign rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= divisor_q;
  assign sign_q  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign quo_ext = {{(RW-WIDTH){1'b0}}, quo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      mplier_q     <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      remainder_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      start_prev_q <= alu_bus.start;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            op_q      <= alu_bus.operation;
            a_q       <= alu_bus.first_nr;
            b_q       <= alu_bus.second_nr;
            mcand_q   <= {{(RW-WIDTH-1){1'b0}}, mag_a};
            mplier_q  <= mag_b;
            acc_q     <= '0;
            divisor_q <= mag_b;
            rem_q     <= '0;
            quo_q     <= mag_a[WIDTH-1:0];
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            // Divide by zero is caught here and finishes through EXEC with err.
            if (alu_bus.operation == OP_MUL ||
                (alu_bus.operation == OP_DIV && alu_bus.second_nr != '0))
              state_q <= S_ITER;
            else
              state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          remainder_q <= '0;
          case (op_q)
            OP_ADD: begin
              result_q <= {{WIDTH{a_q[WIDTH-1]}}, a_q} + {{WIDTH{b_q[WIDTH-1]}}, b_q};
              err_q    <= 1'b0;
            end
            OP_SUB: begin
              result_q <= {{WIDTH{a_q[WIDTH-1]}}, a_q} - {{WIDTH{b_q[WIDTH-1]}}, b_q};
              err_q    <= 1'b0;
            end
            default: begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          endcase
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_ITER: begin
          if (op_q == OP_MUL) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end else begin
            rem_q <= rem_ge ? (rem_sh - divisor_q) : rem_sh;
            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_SIGN;
        end
        S_SIGN: begin
          if (op_q == OP_MUL) begin
            result_q    <= sign_q ? -acc_q : acc_q;
            remainder_q <= '0;
          end else begin
            result_q    <= sign_q ? -quo_ext : quo_ext;
            remainder_q <= WIDTH'(a_q[WIDTH-1] ? -rem_q : rem_q);
          end
          err_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_bus.result    = result_q;
  assign alu_bus.remainder = remainder_q;
  assign alu_bus.busy      = busy_q;
  assign alu_bus.done      = done_q;
  assign alu_bus.err       = err_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq: directed vectors, random operations against an
// integer-arithmetic reference model, start-level handling and mid-operation reset.
module tb_calc_alu_seq;
  localparam int WIDTH = 4;
  localparam int EW    = 1 + 2*WIDTH + WIDTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  calc_alu_if #(.WIDTH(WIDTH)) bus ();

  calc_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_bus (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];   // {err, result, remainder}

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] op, output int lat);
    int sa, sb, r, m;
    logic e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0; m = 0; e = 1'b0; lat = 2;
    case (op)
      4'hA: r = sa + sb;
      4'hB: r = sa - sb;
      4'hC: begin r = sa * sb; lat = 6; end
      4'hD: begin
        if (sb == 0) e = 1'b1;
        else begin r = sa / sb; m = sa % sb; lat = 6; end
      end
      default: e = 1'b1;
    endcase
    return {e, 8'(r), 4'(m)};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; returns one negedge after the done cycle with start low.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       output logic [EW-1:0] got, output int cyc,
                       output logic busy1, output logic seen);
    bus.first_nr  = a;
    bus.second_nr = b;
    bus.operation = op;
    bus.start     = 1'b1;
    cyc = 0; busy1 = 1'b0; seen = 1'b0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = bus.busy;
      seen = bus.done;
    end
    got = {bus.err, bus.result, bus.remainder};
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    bus.start = 1'b0; bus.first_nr = '0; bus.second_nr = '0; bus.operation = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.result, bus.remainder, bus.busy, bus.done, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h rem=%h busy=%b done=%b err=%b, want all 0",
               bus.result, bus.remainder, bus.busy, bus.done, bus.err);
    end
    // start already high while reset releases must launch.
    bus.first_nr = 4'h3; bus.second_nr = 4'hE; bus.operation = 4'hA; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 10 && !bus.done) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (cyc !== 2 || bus.result !== 8'h01 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_reset_release: got cyc=%0d res=%h err=%b, want cyc=2 res=01 err=0",
               cyc, bus.result, bus.err);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    logic [3:0] va[8] = '{4'h3, 4'hD, 4'h8, 4'h7, 4'h8, 4'h5, 4'h2, 4'h6};
    logic [3:0] vb[8] = '{4'hE, 4'h5, 4'h8, 4'hE, 4'hF, 4'h0, 4'h1, 4'h3};
    logic [3:0] vo[8] = '{4'hA, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'h3, 4'hB};
    logic [EW-1:0] want[8] = '{13'h0010, 13'h0F10, 13'h0400, 13'h0FD1,
                               13'h0080, 13'h1000, 13'h1000, 13'h0030};
    int lat[8] = '{2, 6, 6, 6, 6, 2, 2, 2};
    logic [EW-1:0] got, exp;
    int cyc, lat_m;
    logic busy1, seen;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model(va[i], vb[i], vo[i], lat_m));
      do_op(va[i], vb[i], vo[i], got, cyc, busy1, seen);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!seen) begin
        n_fail++;
        $display("FAIL spec_%0d_timeout: no done within 20 cycles", i);
      end
      n_cmp++;
      if (got !== want[i] || exp !== want[i]) begin
        n_fail++;
        $display("FAIL spec_%0d_value: got %h model %h, want %h", i, got, exp, want[i]);
      end
      n_cmp++;
      if (cyc !== lat[i] || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL spec_%0d_timing: got cyc=%0d busy=%b, want cyc=%0d busy=1",
                 i, cyc, busy1, lat[i]);
      end
      n_cmp++;
      if (bus.done !== 1'b0 || {bus.err, bus.result, bus.remainder} !== want[i]) begin
        n_fail++;
        $display("FAIL spec_%0d_hold: got done=%b out=%h, want done=0 out=%h",
                 i, bus.done, {bus.err, bus.result, bus.remainder}, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] a, b, op;
    logic [EW-1:0] got, exp;
    int cyc, lat_m;
    logic busy1, seen;
    for (int i = 0; i < 60; i++) begin
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(10, 13));
      exp_q.push_back(model(a, b, op, lat_m));
      do_op(a, b, op, got, cyc, busy1, seen);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!seen || got !== exp || cyc !== lat_m) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h op=%h: got %h cyc=%0d seen=%b, want %h cyc=%0d",
                 i, a, b, op, got, cyc, seen, exp, lat_m);
      end
    end
  endtask

  task automatic test_start_level();
    int dones;
    logic [EW-1:0] exp;
    int lat_m;
    // Level held high: exactly one operation.
    bus.first_nr = 4'h2; bus.second_nr = 4'h3; bus.operation = 4'hA; bus.start = 1'b1;
    dones = 0;
    repeat (20) begin @(negedge clk); if (bus.done) dones++; end
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dones !== 1 || bus.result !== 8'h05) begin
      n_fail++;
      $display("FAIL start_held: got dones=%0d res=%h, want 1 and 05", dones, bus.result);
    end
    // Second edge during a multiply is ignored.
    exp_q.push_back(model(4'h6, 4'hD, 4'hC, lat_m));
    bus.first_nr = 4'h6; bus.second_nr = 4'hD; bus.operation = 4'hC; bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.first_nr = 4'h1; bus.second_nr = 4'h1; bus.operation = 4'hA; bus.start = 1'b1;
    dones = 0;
    repeat (15) begin @(negedge clk); if (bus.done) dones++; end
    bus.start = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front();
    n_cmp++;
    if (dones !== 1 || {bus.err, bus.result, bus.remainder} !== exp) begin
      n_fail++;
      $display("FAIL edge_while_busy: got dones=%0d out=%h, want 1 and %h",
               dones, {bus.err, bus.result, bus.remainder}, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones, cyc;
    logic [EW-1:0] got;
    logic busy1, seen;
    do_op(4'h7, 4'h7, 4'hC, got, cyc, busy1, seen);   // leaves non-zero outputs behind
    bus.first_nr = 4'hD; bus.second_nr = 4'h5; bus.operation = 4'hC; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.result, bus.remainder, bus.busy, bus.done, bus.err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got res=%h rem=%h busy=%b done=%b err=%b, want all 0",
               bus.result, bus.remainder, bus.busy, bus.done, bus.err);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (10) begin @(negedge clk); if (bus.done) dones++; end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got dones=%0d, want 0", dones);
    end
    do_op(4'hD, 4'h5, 4'hC, got, cyc, busy1, seen);
    n_cmp++;
    if (!seen || got !== 13'h0F10 || cyc !== 6) begin
      n_fail++;
      $display("FAIL after_reset_mul: got %h cyc=%0d seen=%b, want 0f10 cyc=6", got, cyc, seen);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_start_level();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
